seg7_scan_driver: RTL and testbench

- Downstream display stage for every game mode. It consumes the 20-bit `seg_data` character word and the `dp_data` word that the modes produce.
- It time-multiplexes them onto the board's 4-digit common-anode 7-segment display, with:
  - a per-digit ghost-suppression blanking window;
  - frame-synchronous input latching, so no frame mixes old and new characters;
  - per-digit blinking.

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four 5-bit character codes onto a
// 4-digit common-anode 7-segment display. Features:
//   - a dark window at the start of every digit slot to hide ghosting;
//   - shadow registers that latch only at the frame boundary;
//   - per-digit blinking.
// All outputs are registered, so each one reflects the previous cycle's
// counter and shadow state.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int BLINK_DIV    = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [19:0] seg_data,
  input  logic [3:0]  dp_data,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LIM  = SW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Character decode, active-high {g,f,e,d,c,b,a}; unknown codes are blank.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] p;
    case (code)
      5'd0:    p = 7'h3F;
      5'd1:    p = 7'h06;
      5'd2:    p = 7'h5B;
      5'd3:    p = 7'h4F;
      5'd4:    p = 7'h66;
      5'd5:    p = 7'h6D;
      5'd6:    p = 7'h7D;
      5'd7:    p = 7'h07;
      5'd8:    p = 7'h7F;
      5'd9:    p = 7'h6F;
      5'd10:   p = 7'h40;
      5'd15:   p = 7'h3E;
      5'd16:   p = 7'h73;
      5'd17:   p = 7'h5C;
      5'd19:   p = 7'h5E;
      5'd20:   p = 7'h54;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [1:0]     digit_idx_q, digit_idx_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;
  logic [3:0][4:0] sh_char_q;
  logic [3:0]     sh_dp_q, sh_blink_q;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic           frame_start_q;
  logic           slot_wrap, blink_wrap, frame_load, blank_win;

  // Next-state for the slot, digit and blink counters plus the frame-boundary strobe.
  always_comb begin
    slot_wrap     = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_idx_d   = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;
    frame_load    = slot_wrap && (digit_idx_q == 2'd3);
  end

  // Output selection from the current counters and shadow contents.
  always_comb begin
    blank_win = (slot_cnt_q < BLANK_LIM);
    an_d      = 4'b1111;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    if (en && !blank_win) begin
      an_d = ~(4'b0001 << digit_idx_q);
      if (!(sh_blink_q[digit_idx_q] && blink_phase_q)) begin
        seg_d = ~decode(sh_char_q[digit_idx_q]);
        dp_d  = ~sh_dp_q[digit_idx_q];
      end
    end
  end

  // Counters, shadow latch and output registers; reset returns everything to a blank display.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_char_q     <= '1;
      sh_dp_q       <= 4'b0000;
      sh_blink_q    <= 4'b0000;
      an_q          <= 4'b1111;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (frame_load) begin
        sh_char_q  <= seg_data;
        sh_dp_q    <= dp_data;
        sh_blink_q <= blink_mask;
      end
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_load;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. A cycle-count model derives the expected outputs.
// Directed literal checks pin the model at hand-computed points.
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BD = 64;
  localparam int FR = 4 * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [19:0] seg_data;
  logic [3:0]  dp_data;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seg7_scan_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_DIV   (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .seg_data   (seg_data),
    .dp_data    (dp_data),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic logic [6:0] pat(input logic [4:0] code);
    case (code)
      5'd0:  return 7'h3F;
      5'd1:  return 7'h06;
      5'd2:  return 7'h5B;
      5'd3:  return 7'h4F;
      5'd4:  return 7'h66;
      5'd5:  return 7'h6D;
      5'd6:  return 7'h7D;
      5'd7:  return 7'h07;
      5'd8:  return 7'h7F;
      5'd9:  return 7'h6F;
      5'd10: return 7'h40;
      5'd15: return 7'h3E;
      5'd16: return 7'h73;
      5'd17: return 7'h5C;
      5'd19: return 7'h5E;
      5'd20: return 7'h54;
      default: return 7'h00;
    endcase
  endfunction

  // Model: n counts clock edges since reset release. Slot, digit and blink
  // phase are pure arithmetic on n. The shadow is a copy of the inputs taken
  // on every frame-boundary edge.
  int         n;
  int         m_slot, m_dig, m_ph;
  logic [4:0] m_ch [4];
  logic [3:0] m_dp, m_bl;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fs;
  bit         chk_on = 0;

  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      for (int k = 0; k < 4; k++) m_ch[k] = 5'd31;
      m_dp   = 4'b0000;
      m_bl   = 4'b0000;
      e_an   = 4'b1111;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      e_fs   = 1'b0;
      chk_on = 1;
    end else begin
      m_slot = n % RD;
      m_dig  = (n / RD) % 4;
      m_ph   = (n / BD) % 2;
      e_an   = 4'b1111;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      if (en && m_slot >= BC) begin
        e_an[m_dig] = 1'b0;
        if (!(m_bl[m_dig] && m_ph == 1)) begin
          e_seg = ~pat(m_ch[m_dig]);
          e_dp  = ~m_dp[m_dig];
        end
      end
      e_fs = ((n % FR) == FR - 1);
      if (e_fs) begin
        for (int k = 0; k < 4; k++) m_ch[k] = seg_data[5*k +: 5];
        m_dp = dp_data;
        m_bl = blink_mask;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({an, seg, dp, frame_start} === {e_an, e_seg, e_dp, e_fs})
        passes++;
      else
        $display("FAIL cycle n=%0d an=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b (got/expected)",
                 n, an, e_an, seg, e_seg, dp, e_dp, frame_start, e_fs);
    end
  end

  int c;

  task automatic wait_to(input int t);
    while (c < t) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endtask

  int r;

  initial begin
    reset      = 1'b1;
    en         = 1'b1;
    seg_data   = {5'd0, 5'd1, 5'd2, 5'd3};
    dp_data    = 4'b0000;
    blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    c = 0;

    // Reset and first frame: blank until the first load.
    wait_to(1);   chk("post_reset_an", an, 4'b1111);
    wait_to(5);   chk("f0_d0_an", an, 4'b1110);
                  chk("f0_d0_seg", seg, 7'h7F);
    wait_to(31);  chk("fs_before", frame_start, 1'b0);
    wait_to(32);  chk("fs_first", frame_start, 1'b1);
    wait_to(33);  chk("fs_after", frame_start, 1'b0);
    wait_to(36);  chk("f1_d0_seg", seg, 7'h30);
    wait_to(40);  seg_data = {5'd10, 5'd15, 5'd16, 5'd17};
    wait_to(60);  chk("f1_d3_seg", seg, 7'h40);
                  chk("f1_d3_an", an, 4'b0111);

    // Decode sweep.
    wait_to(68);  chk("dec17", seg, 7'h23);
    wait_to(70);  seg_data = {5'd19, 5'd20, 5'd9, 5'd31};
    wait_to(76);  chk("dec16", seg, 7'h0C);
    wait_to(84);  chk("dec15", seg, 7'h41);
    wait_to(92);  chk("dec10", seg, 7'h3F);
    wait_to(100); chk("dec31", seg, 7'h7F);
    wait_to(108); chk("dec9", seg, 7'h10);
    wait_to(116); chk("dec20", seg, 7'h2B);
    wait_to(124); chk("dec19", seg, 7'h21);

    // Frame atomicity: change during digit 1's slot.
    wait_to(138); seg_data = {5'd4, 5'd5, 5'd6, 5'd7};
    wait_to(140); chk("atom_d1_old", seg, 7'h10);
    wait_to(148); chk("atom_d2_old", seg, 7'h2B);
    wait_to(156); chk("atom_d3_old", seg, 7'h21);
    wait_to(160); chk("atom_fs", frame_start, 1'b1);
    wait_to(161); chk("blank_slot0", an, 4'b1111);
    wait_to(163); chk("first_lit_slot2", an, 4'b1110);
    wait_to(164); chk("atom_d0_new", seg, 7'h78);

    // Blink on digit 2, loaded at the same edge as a blink-phase toggle.
    wait_to(170); blink_mask = 4'b0100; dp_data = 4'b0100;
    wait_to(188); chk("atom_d3_new", seg, 7'h19);
    wait_to(212); chk("blink_on_an", an, 4'b1011);
                  chk("blink_on_seg", seg, 7'h7F);
                  chk("blink_on_dp", dp, 1'b1);
    wait_to(268); chk("steady_d1_seg", seg, 7'h02);
                  chk("steady_d1_dp", dp, 1'b1);
    wait_to(275); chk("blink_off_seg", seg, 7'h12);
                  chk("blink_off_dp", dp, 1'b0);
    wait_to(340); chk("blink_on2_an", an, 4'b1011);
                  chk("blink_on2_seg", seg, 7'h7F);

    // Enable drop mid-slot, then reset mid-frame.
    wait_to(348); chk("en_before_an", an, 4'b0111);
                  en = 1'b0;
    wait_to(349); chk("en_off_an", an, 4'b1111);
                  chk("en_off_seg", seg, 7'h7F);
    wait_to(352); en = 1'b1;
    wait_to(357); chk("en_back_an", an, 4'b1110);
                  chk("en_back_seg", seg, 7'h78);
    wait_to(370); reset = 1'b1;
    wait_to(371); chk("rst_an", an, 4'b1111);
                  chk("rst_seg", seg, 7'h7F);
                  chk("rst_dp", dp, 1'b1);
                  chk("rst_fs", frame_start, 1'b0);
    wait_to(373); reset = 1'b0;
    r = 373;
    wait_to(r + 5);  chk("rst_blank_an", an, 4'b1110);
                     chk("rst_blank_seg", seg, 7'h7F);
    wait_to(r + 32); chk("rst_fs_again", frame_start, 1'b1);
    wait_to(r + 36); chk("rst_reload_d0", seg, 7'h78);
    wait_to(r + 45);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
